mux_arb_5to1: RTL and testbench
===============================

MUX_ARB_5TO1 -- requirements
Module: mux_arb_5to1

Interface
REQ-001 SHALL have parameter DATA_W, default 16, flit data width.
REQ-002 SHALL have parameter NPORTS, default 5, number of input ports; fixed at 5, other values unsupported.
REQ-003 SHALL have clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have data_i, input, NPORTS x DATA_W, flit per input port, indexed North=0, South=1, West=2, East=3, Local=4.
REQ-006 SHALL have valid_i, input, NPORTS, flit present per port.
REQ-007 SHALL have last_i, input, NPORTS, tail-flit marker per port, meaningful only with valid_i.
REQ-008 SHALL have ready_o, output, NPORTS, flit accepted per port when valid_i and ready_o are both 1.
REQ-009 SHALL have data_o, output, DATA_W, registered output flit.
REQ-010 SHALL have valid_o, output, 1, data_o holds a flit.
REQ-011 SHALL have last_o, output, 1, registered tail marker of data_o.
REQ-012 SHALL have sel_o, output, 3, source port of data_o (000 N, 001 S, 010 W, 011 E, 100 L).
REQ-013 SHALL have ready_i, input, 1, downstream accepts data_o when valid_o and ready_i are both 1.

Function
REQ-014 SHALL implement FSM states IDLE and LOCKED, plus a 3-bit round-robin pointer rr_ptr (values 0-4).
REQ-015 In IDLE, grant SHALL go to the first port with valid_i=1, searching from rr_ptr upward and wrapping 4->0.
REQ-016 The output register SHALL accept a flit when out_free = !valid_o | ready_i.
REQ-017 ready_o SHALL be 1 only for the granted port and only when out_free=1; all other bits SHALL be 0.
REQ-018 An accepted flit SHALL appear on data_o/last_o/sel_o with valid_o=1 on the next cycle (1-cycle latency).
REQ-019 IDLE->LOCKED SHALL occur on accepting a flit with last_i=0; the grant is held in a register.
REQ-020 In LOCKED, only the held port SHALL be served, regardless of other valid_i.
REQ-021 Accepting a flit with last_i=1 (IDLE or LOCKED) SHALL leave/return to IDLE and set rr_ptr = (grant+1) mod 5.
REQ-022 rr_ptr SHALL change only on tail-flit acceptance.
REQ-023 With valid_o=1 and ready_i=0, data_o, last_o and sel_o SHALL hold stable.
REQ-024 Simultaneous drain (ready_i=1) and accept in one cycle SHALL sustain one flit per cycle with no bubble.
REQ-025 If valid_o=1 and ready_i=1 with no accept, valid_o SHALL go to 0 next cycle.
REQ-026 A held port that drops valid_i mid-packet SHALL stay granted; no other port is served until its tail.
REQ-027 Flits SHALL never be duplicated, dropped or reordered within a port.

Reset
REQ-028 Reset assertion SHALL immediately set valid_o=0, data_o=0, last_o=0, sel_o=000, ready_o=0, state=IDLE, rr_ptr=0.
REQ-029 Reset mid-packet SHALL discard the lock and the output flit; after release, arbitration restarts from North.

Structure
REQ-030 Package noc_pkg SHALL hold DATA_W, NPORTS and enum port_e (PORT_N=0, PORT_S=1, PORT_W=2, PORT_E=3, PORT_L=4), shared with the 1-to-5 demux.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_arbiter_5 (inputs: requests and pointer; outputs: one-hot grant and encoded index).

Verification
REQ-032 Reset release, then N single-flit 0x5555 last=1 -> next cycle data_o=0x5555, sel_o=000, valid_o=1; rr_ptr=1.
REQ-033 All five ports valid, last=1, ready_i=1, data 0x0001-0x0005 -> sel_o sequence 000,001,010,011,100,000 on consecutive cycles.
REQ-034 W sends a 3-flit packet (0xAAA1, 0xAAA2, 0xAAA3 last) while E is valid -> three W flits contiguous, sel_o=010, then E on sel_o=011.
REQ-035 ready_i=0 for 4 cycles with L flit 0xFFFF -> data_o holds 0xFFFF, ready_o=00000 throughout, resumes on ready_i=1.
REQ-036 rst_n_i asserted after the 2nd flit of a 4-flit S packet -> valid_o=0 immediately; after release, N request is granted first.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit width, port count and port ids.
// Used by both the 5-to-1 output arbiter and the 1-to-5 demux.
package noc_pkg;

    localparam int DATA_W = 16;
    localparam int NPORTS = 5;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_S = 3'd1,
        PORT_W = 3'd2,
        PORT_E = 3'd3,
        PORT_L = 3'd4
    } port_e;

    // Next port id in round-robin order, wrapping L back to N.
    function automatic logic [2:0] next_port(input logic [2:0] p);
        return (p >= 3'd4) ? 3'd0 : p + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter_5.sv
// Combinational 5-way round-robin arbiter: first requester at or
// after the pointer wins, wrapping from L back to N.
module rr_arbiter_5
    import noc_pkg::*;
(
    input  logic [4:0] req_i,
    input  logic [2:0] ptr_i,
    output logic [4:0] gnt_o,
    output logic [2:0] idx_o
);

    logic [2:0] cand;
    logic       found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = ptr_i;
        found = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
            cand = next_port(cand);
        end
    end

endmodule

// File: rtl/mux_arb_5to1.sv
// 5-to-1 wormhole output arbiter: packet-locked round-robin grant
// feeding a single registered output flit stage.
module mux_arb_5to1 #(
    parameter int DATA_W = noc_pkg::DATA_W,
    parameter int NPORTS = noc_pkg::NPORTS
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NPORTS*DATA_W-1:0] data_i,
    input  logic [NPORTS-1:0]        valid_i,
    input  logic [NPORTS-1:0]        last_i,
    output logic [NPORTS-1:0]        ready_o,
    output logic [DATA_W-1:0]        data_o,
    output logic                     valid_o,
    output logic                     last_o,
    output logic [2:0]               sel_o,
    input  logic                     ready_i
);

    import noc_pkg::*;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e      state_q;
    port_e       held_q;
    logic [2:0]  rr_ptr;

    logic [4:0]  arb_gnt;
    logic [2:0]  arb_idx;
    logic [4:0]  gnt_oh;
    logic [2:0]  gnt_idx;
    logic        out_free;
    logic        accept;
    logic        acc_last;
    logic [DATA_W-1:0] acc_data;

    rr_arbiter_5 u_arb (
        .req_i (valid_i),
        .ptr_i (rr_ptr),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // A locked packet owns the output even while its port is idle.
    always_comb begin
        gnt_oh  = arb_gnt;
        gnt_idx = arb_idx;
        if (state_q == LOCKED) begin
            gnt_oh  = 5'b00001 << held_q;
            gnt_idx = held_q;
        end
    end

    assign out_free = !valid_o || ready_i;
    assign ready_o  = rst_n_i ? (gnt_oh & {5{out_free}}) : '0;
    assign accept   = |(ready_o & valid_i);
    assign acc_data = data_i[gnt_idx*DATA_W +: DATA_W];
    assign acc_last = last_i[gnt_idx];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            held_q  <= PORT_N;
            rr_ptr  <= 3'd0;
            valid_o <= 1'b0;
            data_o  <= '0;
            last_o  <= 1'b0;
            sel_o   <= 3'd0;
        end else if (accept) begin
            valid_o <= 1'b1;
            data_o  <= acc_data;
            last_o  <= acc_last;
            sel_o   <= gnt_idx;
            if (acc_last) begin
                state_q <= IDLE;
                rr_ptr  <= next_port(gnt_idx);
            end else begin
                state_q <= LOCKED;
                held_q  <= port_e'(gnt_idx);
            end
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_5to1.sv
// Bench for mux_arb_5to1: packet-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mux_arb_5to1;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic [79:0] data_i;
    logic [4:0]  valid_i;
    logic [4:0]  last_i;
    logic [4:0]  ready_o;
    logic [15:0] data_o;
    logic        valid_o;
    logic        last_o;
    logic [2:0]  sel_o;
    logic        ready_i;

    int n_chk = 0;
    int n_err = 0;

    mux_arb_5to1 dut (
        .clk_i   (clk),
        .rst_n_i (rst_n_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .last_i  (last_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .last_o  (last_o),
        .sel_o   (sel_o),
        .ready_i (ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: packet owner, round-robin start, output slot.
    logic        m_valid  = 1'b0;
    logic [15:0] m_data   = '0;
    logic        m_last   = 1'b0;
    int          m_sel    = 0;
    logic        m_locked = 1'b0;
    int          m_held   = 0;
    int          m_ptr    = 0;

    function automatic int m_owner();
        if (m_locked) return m_held;
        for (int k = 0; k < 5; k++)
            if (valid_i[(m_ptr + k) % 5]) return (m_ptr + k) % 5;
        return -1;
    endfunction

    function automatic logic [4:0] m_ready();
        int o;
        if (!rst_n_i) return 5'b0;
        if (m_valid && !ready_i) return 5'b0;
        o = m_owner();
        if (o < 0) return 5'b0;
        return 5'b1 << o;
    endfunction

    always @(posedge clk or negedge rst_n_i) begin
        int p;
        if (!rst_n_i) begin
            m_valid = 0; m_data = 0; m_last = 0; m_sel = 0;
            m_locked = 0; m_held = 0; m_ptr = 0;
        end else if (|(m_ready() & valid_i)) begin
            p = m_owner();
            m_valid = 1;
            m_data  = data_i[p*16 +: 16];
            m_last  = last_i[p];
            m_sel   = p;
            if (last_i[p]) begin
                m_locked = 0;
                m_ptr    = (p + 1) % 5;
            end else begin
                m_locked = 1;
                m_held   = p;
            end
        end else if (ready_i) begin
            m_valid = 0;
        end
    end

    always @(negedge clk) begin
        chk("ready_o", 32'(ready_o), 32'(m_ready()));
        chk("valid_o", 32'(valid_o), 32'(m_valid));
        if (m_valid) begin
            chk("data_o", 32'(data_o), 32'(m_data));
            chk("last_o", 32'(last_o), 32'(m_last));
            chk("sel_o", 32'(sel_o), 32'(m_sel));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [15:0] d,
                            input logic v, input logic l);
        data_i[p*16 +: 16] = d;
        valid_i[p] = v;
        last_i[p]  = l;
    endtask

    task automatic clear_in();
        data_i  = '0;
        valid_i = '0;
        last_i  = '0;
    endtask

    task automatic do_reset();
        clear_in();
        ready_i = 1'b1;
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
    endtask

    initial begin
        rst_n_i = 1'b0;
        ready_i = 1'b1;
        clear_in();
        valid_i = 5'h1f;
        last_i  = 5'h1f;
        #2;
        chk("rst valid_o", 32'(valid_o), 0);
        chk("rst data_o", 32'(data_o), 0);
        chk("rst sel_o", 32'(sel_o), 0);
        chk("rst ready_o", 32'(ready_o), 0);
        tick();
        clear_in();
        rst_n_i = 1'b1;

        // Single North tail flit.
        set_port(0, 16'h5555, 1, 1);
        tick();
        chk("n1 data", 32'(data_o), 32'h5555);
        chk("n1 sel", 32'(sel_o), 0);
        chk("n1 valid", 32'(valid_o), 1);
        chk("n1 rr_ptr", 32'(dut.rr_ptr), 1);
        clear_in();
        tick();

        // All ports busy with single-flit packets: strict rotation.
        do_reset();
        for (int p = 0; p < 5; p++) set_port(p, 16'(p + 1), 1, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rot sel", 32'(sel_o), 32'(i % 5));
            chk("rot data", 32'(data_o), 32'(i % 5 + 1));
        end
        clear_in();
        tick();

        // West 3-flit packet with East waiting.
        do_reset();
        set_port(2, 16'hAAA1, 1, 0);
        set_port(3, 16'hEEEE, 1, 1);
        tick();
        chk("w1 data", 32'(data_o), 32'hAAA1);
        chk("w1 sel", 32'(sel_o), 2);
        set_port(2, 16'hAAA2, 1, 0);
        tick();
        chk("w2 data", 32'(data_o), 32'hAAA2);
        chk("w2 sel", 32'(sel_o), 2);
        set_port(2, 16'hAAA3, 1, 1);
        tick();
        chk("w3 data", 32'(data_o), 32'hAAA3);
        chk("w3 last", 32'(last_o), 1);
        set_port(2, 16'h0, 0, 0);
        tick();
        chk("e data", 32'(data_o), 32'hEEEE);
        chk("e sel", 32'(sel_o), 3);
        clear_in();
        tick();

        // Local flit stalled downstream for four cycles.
        do_reset();
        ready_i = 1'b0;
        set_port(4, 16'hFFFF, 1, 1);
        tick();
        chk("l data", 32'(data_o), 32'hFFFF);
        set_port(4, 16'h1234, 1, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall data", 32'(data_o), 32'hFFFF);
            chk("stall ready", 32'(ready_o), 0);
        end
        ready_i = 1'b1;
        #1;
        chk("resume ready", 32'(ready_o), 32'h10);
        tick();
        chk("resume data", 32'(data_o), 32'h1234);
        chk("resume sel", 32'(sel_o), 4);
        clear_in();
        tick();
        chk("drain valid", 32'(valid_o), 0);

        // Held South port goes idle mid-packet; North must wait.
        do_reset();
        set_port(1, 16'h2001, 1, 0);
        tick();
        set_port(1, 16'h0, 0, 0);
        set_port(0, 16'h0101, 1, 1);
        tick();
        chk("gap valid", 32'(valid_o), 0);
        chk("gap ready", 32'(ready_o), 32'h02);
        set_port(1, 16'h2002, 1, 1);
        tick();
        chk("gap tail", 32'(data_o), 32'h2002);
        set_port(1, 16'h0, 0, 0);
        tick();
        chk("gap n sel", 32'(sel_o), 0);
        chk("gap n data", 32'(data_o), 32'h0101);
        clear_in();
        tick();

        // Reset in the middle of a South packet.
        do_reset();
        set_port(1, 16'h3001, 1, 0);
        tick();
        set_port(1, 16'h3002, 1, 0);
        tick();
        rst_n_i = 1'b0;
        #1;
        chk("mid rst valid", 32'(valid_o), 0);
        chk("mid rst ready", 32'(ready_o), 0);
        set_port(1, 16'h3003, 1, 0);
        set_port(0, 16'h1111, 1, 1);
        tick();
        rst_n_i = 1'b1;
        tick();
        chk("post rst sel", 32'(sel_o), 0);
        chk("post rst data", 32'(data_o), 32'h1111);
        clear_in();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
